// File: rtl/fp_mult_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : fp_mult_operand_loader
// Description : Sequential front-end for the combinational single-precision
//               multiplier. Assembles operands A and B from a byte stream,
//               drives them onto dataA/dataB, waits SETTLE_CYCLES edges,
//               captures dataR/casesspecial and presents the result on a
//               valid/ready port.
//               Optional macro FP_LOADER_LSB_FIRST_EN selects LSB-first byte
//               ordering (default is MSB-first).
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mult_operand_loader #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        abort,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] dataA,
   output logic [31:0] dataB,
   input  logic [31:0] dataR,
   input  logic [3:0]  casesspecial,
   output logic [31:0] res_data,
   output logic [3:0]  res_special,
   output logic        res_valid,
   input  logic        res_ready,
   output logic        busy
);

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      SETTLE = 2'd2,
      OUTPUT = 2'd3
   } state_t;

   // Settle count value on which the multiplier output is sampled
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t     state;
   state_t     state_next;
   logic [1:0] byte_cnt;
   logic [1:0] byte_cnt_next;
   logic [3:0] settle_cnt;
   logic [3:0] settle_cnt_next;
   logic       xfer;
   logic       shift_a;
   logic       shift_b;
   logic       capture;
   logic       release_res;

   // in_ready is only ever high in the load states, so this is the full handshake
   assign xfer = in_valid & in_ready;

   // Insert one byte into an operand word in the configured order
   function automatic logic [31:0] shift_in(input logic [31:0] cur, input logic [7:0] b);
`ifdef FP_LOADER_LSB_FIRST_EN
      return {b, cur[31:8]};
`else
      return {cur[23:0], b};
`endif
   endfunction

   // State and counter registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= LOAD_A;
         byte_cnt   <= 2'd0;
         settle_cnt <= 4'd0;
      end else begin
         state      <= state_next;
         byte_cnt   <= byte_cnt_next;
         settle_cnt <= settle_cnt_next;
      end
   end

   // Next-state logic and datapath strobes; abort overrides everything
   always_comb begin
      state_next      = state;
      byte_cnt_next   = byte_cnt;
      settle_cnt_next = settle_cnt;
      shift_a         = 1'b0;
      shift_b         = 1'b0;
      capture         = 1'b0;
      release_res     = 1'b0;
      if (abort) begin
         state_next      = LOAD_A;
         byte_cnt_next   = 2'd0;
         settle_cnt_next = 4'd0;
      end else begin
         case (state)
            LOAD_A: begin
               if (xfer) begin
                  shift_a       = 1'b1;
                  byte_cnt_next = byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     state_next = LOAD_B;
                  end
               end
            end
            LOAD_B: begin
               if (xfer) begin
                  shift_b       = 1'b1;
                  byte_cnt_next = byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     state_next      = SETTLE;
                     settle_cnt_next = 4'd0;
                  end
               end
            end
            SETTLE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  capture         = 1'b1;
                  state_next      = OUTPUT;
                  settle_cnt_next = 4'd0;
               end else begin
                  settle_cnt_next = settle_cnt + 4'd1;
               end
            end
            OUTPUT: begin
               if (res_ready) begin
                  release_res = 1'b1;
                  state_next  = LOAD_A;
               end
            end
            default: begin
               state_next = LOAD_A;
            end
         endcase
      end
   end

   // Registered outputs: operands, captured result and status flags
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         dataA       <= 32'd0;
         dataB       <= 32'd0;
         res_data    <= 32'd0;
         res_special <= 4'd0;
         res_valid   <= 1'b0;
         in_ready    <= 1'b0;
         busy        <= 1'b0;
      end else begin
         in_ready <= (state_next == LOAD_A) || (state_next == LOAD_B);
         busy     <= !((state_next == LOAD_A) && (byte_cnt_next == 2'd0));
         if (abort) begin
            // Captured result survives an abort; operands do not
            dataA     <= 32'd0;
            dataB     <= 32'd0;
            res_valid <= 1'b0;
         end else begin
            if (shift_a) begin
               dataA <= shift_in(dataA, in_data);
            end
            if (shift_b) begin
               dataB <= shift_in(dataB, in_data);
            end
            if (capture) begin
               res_data    <= dataR;
               res_special <= casesspecial;
               res_valid   <= 1'b1;
            end else if (release_res) begin
               res_valid <= 1'b0;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fp_mult_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_mult_operand_loader
// Description : Self-checking bench for fp_mult_operand_loader. Instance 0
//               uses SETTLE_CYCLES=1, instance 1 uses SETTLE_CYCLES=3. A stub
//               multiplier drives dataR/casesspecial from the DUT operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_mult_operand_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n      [2];
   logic        abort        [2];
   logic [7:0]  in_data      [2];
   logic        in_valid     [2];
   logic        in_ready     [2];
   logic [31:0] dataA        [2];
   logic [31:0] dataB        [2];
   logic [31:0] dataR        [2];
   logic [3:0]  casesspecial [2];
   logic [31:0] res_data     [2];
   logic [3:0]  res_special  [2];
   logic        res_valid    [2];
   logic        res_ready    [2];
   logic        busy         [2];
   logic        use_force    [2];
   logic [31:0] force_r      [2];

   int total = 0;
   int bad   = 0;
   logic [31:0] last_res;

   fp_mult_operand_loader #(.SETTLE_CYCLES(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n[0]), .abort(abort[0]),
      .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .dataA(dataA[0]), .dataB(dataB[0]), .dataR(dataR[0]),
      .casesspecial(casesspecial[0]), .res_data(res_data[0]),
      .res_special(res_special[0]), .res_valid(res_valid[0]),
      .res_ready(res_ready[0]), .busy(busy[0])
   );

   fp_mult_operand_loader #(.SETTLE_CYCLES(3)) u_dut3 (
      .clk(clk), .reset_n(reset_n[1]), .abort(abort[1]),
      .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .dataA(dataA[1]), .dataB(dataB[1]), .dataR(dataR[1]),
      .casesspecial(casesspecial[1]), .res_data(res_data[1]),
      .res_special(res_special[1]), .res_valid(res_valid[1]),
      .res_ready(res_ready[1]), .busy(busy[1])
   );

   // Stub multiplier: a few exact products, otherwise a scrambled mix
   function automatic logic [31:0] stub_r(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h40FC0000 && b == 32'h3E400000) return 32'h3FBD0000;
      if (a == 32'h00000000 && b == 32'h7F800000) return 32'h7FC00000;
      if (a == 32'hC1900000 && b == 32'h41180000) return 32'hC32B0000;
      return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A5A5A;
   endfunction

   function automatic logic [3:0] stub_s(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h00000000 && b == 32'h7F800000) return 4'b0001;
      if (a == 32'h40FC0000 || a == 32'hC1900000) return 4'b0000;
      return a[3:0] ^ b[7:4];
   endfunction

   // Byte i (in stream order) of an operand word
   function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
`ifdef FP_LOADER_LSB_FIRST_EN
      return w[8*i +: 8];
`else
      return w[8*(3-i) +: 8];
`endif
   endfunction

   always_comb begin
      for (int u = 0; u < 2; u++) begin
         dataR[u]        = use_force[u] ? force_r[u] : stub_r(dataA[u], dataB[u]);
         casesspecial[u] = stub_s(dataA[u], dataB[u]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input int u, input logic [7:0] b);
      int n;
      n = 0;
      in_valid[u] = 1'b1;
      in_data[u]  = b;
      while (in_ready[u] !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      total++;
      if (in_ready[u] !== 1'b1) begin
         bad++;
         $display("FAIL send_byte_u%0d: in_ready=%b required=1 after %0d cycles", u, in_ready[u], n);
      end
      tick();
      in_valid[u] = 1'b0;
      in_data[u]  = 8'h00;
   endtask

   task automatic send_word(input int u, input logic [31:0] w, input int nbytes, input bit gaps);
      for (int i = 0; i < nbytes; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) tick();
         end
         send_byte(u, byte_of(w, i));
      end
   endtask

   task automatic wait_valid(input int u, output int lat);
      lat = 0;
      while (res_valid[u] !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      for (int u = 0; u < 2; u++) begin
         reset_n[u] = 1'b0;
      end
      tick();
      tick();
      for (int u = 0; u < 2; u++) begin
         total++;
         if ({dataA[u], dataB[u], res_data[u], res_special[u], res_valid[u], busy[u], in_ready[u]} !== '0) begin
            bad++;
            $display("FAIL reset_vals_u%0d: A=%h B=%h R=%h S=%b v=%b busy=%b rdy=%b required all 0",
                     u, dataA[u], dataB[u], res_data[u], res_special[u], res_valid[u], busy[u], in_ready[u]);
         end
         reset_n[u] = 1'b1;
      end
      tick();
      for (int u = 0; u < 2; u++) begin
         total++;
         if (in_ready[u] !== 1'b1 || busy[u] !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_u%0d: in_ready=%b busy=%b required 1/0", u, in_ready[u], busy[u]);
         end
      end
      last_res = 32'd0;
   endtask

   task automatic test_basic();
      logic [31:0] a, b;
      a = 32'h40FC0000;
      b = 32'h3E400000;
      res_ready[0] = 1'b1;
      send_word(0, a, 4, 1'b0);
      total++;
      if (dataA[0] !== a || dataB[0] !== 32'd0 || busy[0] !== 1'b1 || in_ready[0] !== 1'b1) begin
         bad++;
         $display("FAIL basic_after_A: A=%h B=%h busy=%b rdy=%b required %h 0 1 1", dataA[0], dataB[0], busy[0], in_ready[0], a);
      end
      send_word(0, b, 4, 1'b0);
      total++;
      if (dataB[0] !== b || dataA[0] !== a || in_ready[0] !== 1'b0 || res_valid[0] !== 1'b0) begin
         bad++;
         $display("FAIL basic_after_B: A=%h B=%h rdy=%b v=%b required %h %h 0 0", dataA[0], dataB[0], in_ready[0], res_valid[0], a, b);
      end
      tick();
      total++;
      if (res_valid[0] !== 1'b1 || res_data[0] !== 32'h3FBD0000 || res_special[0] !== 4'b0000 || in_ready[0] !== 1'b0) begin
         bad++;
         $display("FAIL basic_capture: v=%b R=%h S=%b rdy=%b required 1 3fbd0000 0000 0", res_valid[0], res_data[0], res_special[0], in_ready[0]);
      end
      tick();
      total++;
      if (res_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0 || res_data[0] !== 32'h3FBD0000 || dataA[0] !== a) begin
         bad++;
         $display("FAIL basic_handshake: v=%b rdy=%b busy=%b R=%h A=%h", res_valid[0], in_ready[0], busy[0], res_data[0], dataA[0]);
      end
      res_ready[0] = 1'b0;
      last_res = 32'h3FBD0000;
   endtask

   task automatic test_special();
      int lat;
      send_word(0, 32'h00000000, 4, 1'b1);
      send_word(0, 32'h7F800000, 4, 1'b1);
      wait_valid(0, lat);
      total++;
      if (lat != 1 || res_data[0] !== 32'h7FC00000 || res_special[0] !== 4'b0001) begin
         bad++;
         $display("FAIL special: lat=%0d R=%h S=%b required 1 7fc00000 0001", lat, res_data[0], res_special[0]);
      end
      res_ready[0] = 1'b1;
      tick();
      res_ready[0] = 1'b0;
      last_res = 32'h7FC00000;
   endtask

   task automatic test_backpressure();
      logic [31:0] a, b, exp_r;
      int lat;
      a = $urandom();
      b = $urandom();
      exp_r = stub_r(a, b);
      send_word(0, a, 4, 1'b0);
      send_word(0, b, 4, 1'b0);
      wait_valid(0, lat);
      in_valid[0] = 1'b1;
      in_data[0]  = 8'hAA;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if (res_valid[0] !== 1'b1 || res_data[0] !== exp_r || in_ready[0] !== 1'b0 || dataA[0] !== a || dataB[0] !== b) begin
            bad++;
            $display("FAIL backpressure_hold%0d: v=%b R=%h rdy=%b A=%h B=%h required 1 %h 0 %h %h",
                     i, res_valid[0], res_data[0], in_ready[0], dataA[0], dataB[0], exp_r, a, b);
         end
      end
      res_ready[0] = 1'b1;
      tick();
      in_valid[0]  = 1'b0;
      res_ready[0] = 1'b0;
      total++;
      if (res_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || dataA[0] !== a || res_data[0] !== exp_r) begin
         bad++;
         $display("FAIL backpressure_release: v=%b rdy=%b A=%h R=%h required 0 1 %h %h", res_valid[0], in_ready[0], dataA[0], res_data[0], a, exp_r);
      end
      last_res = exp_r;
   endtask

   task automatic test_abort();
      int lat;
      send_word(0, $urandom(), 4, 1'b1);
      send_word(0, $urandom(), 2, 1'b1);
      abort[0]    = 1'b1;
      in_valid[0] = 1'b1;
      in_data[0]  = 8'h77;
      tick();
      abort[0]    = 1'b0;
      in_valid[0] = 1'b0;
      total++;
      if (dataA[0] !== 32'd0 || dataB[0] !== 32'd0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0 ||
          res_valid[0] !== 1'b0 || res_data[0] !== last_res) begin
         bad++;
         $display("FAIL abort_clear: A=%h B=%h rdy=%b busy=%b v=%b R=%h required 0 0 1 0 0 %h",
                  dataA[0], dataB[0], in_ready[0], busy[0], res_valid[0], res_data[0], last_res);
      end
      send_word(0, 32'hC1900000, 4, 1'b0);
      send_word(0, 32'h41180000, 4, 1'b0);
      total++;
      if (res_data[0] !== last_res || res_valid[0] !== 1'b0) begin
         bad++;
         $display("FAIL abort_retain: R=%h v=%b required %h 0", res_data[0], res_valid[0], last_res);
      end
      wait_valid(0, lat);
      total++;
      if (lat != 1 || dataA[0] !== 32'hC1900000 || dataB[0] !== 32'h41180000 || res_data[0] !== 32'hC32B0000) begin
         bad++;
         $display("FAIL abort_reload: lat=%0d A=%h B=%h R=%h required 1 c1900000 41180000 c32b0000", lat, dataA[0], dataB[0], res_data[0]);
      end
      last_res = 32'hC32B0000;
      // Abort while the result is waiting: result is dropped but data kept
      abort[0] = 1'b1;
      tick();
      abort[0] = 1'b0;
      total++;
      if (res_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || res_data[0] !== last_res || dataA[0] !== 32'd0) begin
         bad++;
         $display("FAIL abort_output: v=%b rdy=%b R=%h A=%h required 0 1 %h 0", res_valid[0], in_ready[0], res_data[0], dataA[0], last_res);
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      int lat;
      for (int n = 0; n < 25; n++) begin
         a = $urandom();
         b = $urandom();
         send_word(0, a, 4, 1'b1);
         send_word(0, b, 4, 1'b1);
         wait_valid(0, lat);
         total++;
         if (lat != 1 || res_data[0] !== stub_r(a, b) || res_special[0] !== stub_s(a, b) || dataA[0] !== a || dataB[0] !== b) begin
            bad++;
            $display("FAIL random%0d: lat=%0d R=%h S=%b A=%h B=%h required 1 %h %b %h %h",
                     n, lat, res_data[0], res_special[0], dataA[0], dataB[0], stub_r(a, b), stub_s(a, b), a, b);
         end
         repeat ($urandom_range(0, 3)) tick();
         res_ready[0] = 1'b1;
         tick();
         res_ready[0] = 1'b0;
         total++;
         if (res_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
            bad++;
            $display("FAIL random%0d_release: v=%b rdy=%b busy=%b required 0 1 0", n, res_valid[0], in_ready[0], busy[0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b;
      res_ready[0] = 1'b1;
      for (int n = 0; n < 3; n++) begin
         a = $urandom();
         b = $urandom();
         send_word(0, a, 4, 1'b0);
         send_word(0, b, 4, 1'b0);
         tick();
         total++;
         if (res_valid[0] !== 1'b1 || res_data[0] !== stub_r(a, b)) begin
            bad++;
            $display("FAIL b2b%0d_capture: v=%b R=%h required 1 %h", n, res_valid[0], res_data[0], stub_r(a, b));
         end
         tick();
         total++;
         if (res_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL b2b%0d_ready: v=%b rdy=%b required 0 1", n, res_valid[0], in_ready[0]);
         end
      end
      res_ready[0] = 1'b0;
   endtask

   task automatic test_settle_reset();
      logic [31:0] a, b;
      use_force[1] = 1'b1;
      force_r[1]   = 32'h11111111;
      a = $urandom();
      b = $urandom();
      send_word(1, a, 4, 1'b0);
      send_word(1, b, 4, 1'b0);
      total++;
      if (in_ready[1] !== 1'b0 || res_valid[1] !== 1'b0) begin
         bad++;
         $display("FAIL settle_enter: rdy=%b v=%b required 0 0", in_ready[1], res_valid[1]);
      end
      tick();
      force_r[1] = 32'h22222222;
      total++;
      if (res_valid[1] !== 1'b0) begin
         bad++;
         $display("FAIL settle_edge1: v=%b required 0", res_valid[1]);
      end
      tick();
      total++;
      if (res_valid[1] !== 1'b0) begin
         bad++;
         $display("FAIL settle_edge2: v=%b required 0", res_valid[1]);
      end
      tick();
      total++;
      if (res_valid[1] !== 1'b1 || res_data[1] !== 32'h22222222 || in_ready[1] !== 1'b0) begin
         bad++;
         $display("FAIL settle_capture: v=%b R=%h rdy=%b required 1 22222222 0", res_valid[1], res_data[1], in_ready[1]);
      end
      res_ready[1] = 1'b1;
      tick();
      res_ready[1] = 1'b0;
      use_force[1] = 1'b0;
      // Reset asserted in the middle of a settle window
      send_word(1, $urandom(), 4, 1'b0);
      send_word(1, $urandom(), 4, 1'b0);
      tick();
      reset_n[1] = 1'b0;
      tick();
      total++;
      if ({dataA[1], dataB[1], res_data[1], res_special[1], res_valid[1], busy[1], in_ready[1]} !== '0) begin
         bad++;
         $display("FAIL settle_reset: A=%h B=%h R=%h S=%b v=%b busy=%b rdy=%b required all 0",
                  dataA[1], dataB[1], res_data[1], res_special[1], res_valid[1], busy[1], in_ready[1]);
      end
      reset_n[1] = 1'b1;
      tick();
      total++;
      if (in_ready[1] !== 1'b1 || busy[1] !== 1'b0) begin
         bad++;
         $display("FAIL settle_reset_release: rdy=%b busy=%b required 1 0", in_ready[1], busy[1]);
      end
   endtask

   initial begin
      for (int u = 0; u < 2; u++) begin
         reset_n[u]   = 1'b0;
         abort[u]     = 1'b0;
         in_data[u]   = 8'h00;
         in_valid[u]  = 1'b0;
         res_ready[u] = 1'b0;
         use_force[u] = 1'b0;
         force_r[u]   = 32'd0;
      end
      last_res = 32'd0;
      test_reset();
      test_basic();
      test_special();
      test_backpressure();
      test_abort();
      test_random();
      test_back_to_back();
      test_settle_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/fp_mult_operand_loader.md
Name: fp_mult_operand_loader

Overview:
- Sequential front-end for the combinational single-precision multiplier unit.
- Assembles operands A and B from a byte-wide valid/ready stream and drives them onto the multiplier's dataA/dataB inputs.
- Waits a programmable settle time, then registers the multiplier's dataR and casesspecial outputs.
- Presents the captured result on a valid/ready result port. This is the only path by which the multiplier is loaded and read in the datapath.

Parameters:
- SETTLE_CYCLES, 1: clock cycles allowed for the multiplier's combinational path before capture; legal range 1..15.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset_n  input  1  synchronous, active-low reset
- abort  input  1  synchronous clear of the current operation
- in_data  input  8  operand byte
- in_valid  input  1  in_data is valid
- in_ready  output  1  loader accepts a byte this cycle
- dataA  output  32  operand A to the multiplier
- dataB  output  32  operand B to the multiplier
- dataR  input  32  product from the multiplier
- casesspecial  input  4  special-case flags from the multiplier: {Zero, Inf, -Inf, NaN}
- res_data  output  32  captured product
- res_special  output  4  captured casesspecial
- res_valid  output  1  res_data and res_special are valid
- res_ready  input  1  consumer accepts the result
- busy  output  1  high in any state other than LOAD_A with byte count 0

Behaviour:
- Clocking and reset: one clock, clk. reset_n is synchronous and active-low. Priority is reset_n, then abort, then normal operation.
- Reset values: state LOAD_A, byte count 0, settle count 0. dataA, dataB, res_data = 0. res_special = 0. res_valid = 0, busy = 0. in_ready = 0 while reset_n is low; in_ready = 1 on the first edge after release.
- Outputs: all outputs are registered. in_ready is registered from next-state: it is 1 iff next state is LOAD_A or LOAD_B.
- Byte transfer: a byte transfers on an edge where in_valid and in_ready are both 1. in_data is ignored otherwise.
- LOAD_A: each transfer does dataA <= {dataA[23:0], in_data} (MSB first) and increments the byte count. The 4th transfer resets the count to 0 and moves to LOAD_B. dataB is unchanged.
- LOAD_B: same shifting into dataB. The 4th transfer moves to SETTLE with settle count 0, and in_ready drops on that same edge.
- SETTLE: the settle count increments on each edge. On the edge where the count equals SETTLE_CYCLES-1:
  - res_data <= dataR, res_special <= casesspecial, res_valid <= 1;
  - go to OUTPUT.
- Latency: with SETTLE_CYCLES=1, res_valid rises on the edge immediately after the edge that accepted byte 8. In general the latency is SETTLE_CYCLES edges.
- OUTPUT: dataA and dataB are held. res_valid stays 1 until an edge with res_ready=1. On that edge res_valid <= 0, go to LOAD_A, in_ready <= 1.
- Result persistence: res_data and res_special hold their values until the next capture.
- Back-to-back operation: the first byte of the next A can transfer one edge after the result handshake. There is no overlap of loading with OUTPUT.
- Operand contents: no interpretation is applied. Denormals, NaN and Inf pass through unchanged. The special-case flags come solely from casesspecial.
- abort=1, in any state:
  - go to LOAD_A; byte and settle counts = 0;
  - res_valid = 0; in_ready = 1;
  - dataA, dataB = 0;
  - res_data and res_special are retained.
  - A byte presented on an abort edge is not accepted.
- reset_n low mid-operation: full return to reset values on that edge, including res_data.

Optional Feature:
- Macro FP_LOADER_LSB_FIRST_EN.
- Defined: bytes are shifted in LSB first, i.e. dataX <= {in_data, dataX[31:8]}. The first byte lands in [7:0] after 4 transfers.
- Undefined: MSB-first ordering as above.
- No other behaviour changes.

Test Plan:
- Basic load and capture:
  - Stimulus: stub multiplier returns dataR=0x3FBD0000, casesspecial=0 when dataA=0x40FC0000 and dataB=0x3E400000. Stream bytes 40 FC 00 00 3E 40 00 00, SETTLE_CYCLES=1, res_ready=1.
  - Response: dataA=0x40FC0000 after 4 transfers, dataB=0x3E400000 after 8. res_valid high exactly 1 cycle after byte 8 with res_data=0x3FBD0000. in_ready low in SETTLE and OUTPUT.
- Special-case capture:
  - Stimulus: A=0x00000000, B=0x7F800000; stub returns dataR=0x7FC00000, casesspecial=4'b0001.
  - Response: res_special=4'b0001, res_data=0x7FC00000.
- Backpressure:
  - Stimulus: res_ready held 0 for 5 cycles after res_valid, with in_valid=1 and bytes 0xAA offered.
  - Response: res_valid and res_data stable, in_ready=0, no bytes absorbed. After res_ready=1 for one edge, res_valid=0 and in_ready=1 on the next cycle.
- Abort mid-B:
  - Stimulus: abort pulsed after 6 bytes, then bytes C1 90 00 00 41 18 00 00 streamed.
  - Response: dataA=0 and dataB=0 after the abort. Final dataA=0xC1900000, dataB=0x41180000. One res_valid with the stub's value; the earlier res_data is retained up to that capture.
- Settle timing and reset:
  - Stimulus: SETTLE_CYCLES=3; stub changes dataR from 0x11111111 to 0x22222222 on the 2nd cycle of SETTLE. Second run: reset_n low during SETTLE.
  - Response: first run captures 0x22222222, with res_valid 3 cycles after byte 8. Second run: all outputs at reset values on the next edge and in_ready=1 after release.
- Byte order macro:
  - Stimulus: FP_LOADER_LSB_FIRST_EN defined, bytes 00 00 FC 40 00 00 40 3E.
  - Response: dataA=0x40FC0000, dataB=0x3E400000.
